// File: rtl/lc3b_types.sv
// Shared LC-3b widths and opcode encoding for the pipeline stages.
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [2:0]  lc3b_reg;

   typedef enum logic [3:0] {
      op_br   = 4'b0000,
      op_add  = 4'b0001,
      op_ldb  = 4'b0010,
      op_stb  = 4'b0011,
      op_jsr  = 4'b0100,
      op_and  = 4'b0101,
      op_ldr  = 4'b0110,
      op_str  = 4'b0111,
      op_rti  = 4'b1000,
      op_not  = 4'b1001,
      op_ldi  = 4'b1010,
      op_sti  = 4'b1011,
      op_jmp  = 4'b1100,
      op_shf  = 4'b1101,
      op_lea  = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;

   // BR with nzp=000 never branches, so an all-zero word is a safe NOP.
   localparam lc3b_word nop_word = 16'h0000;

endpackage

// File: rtl/id_decode.sv
// Combinational register-field decode of the instruction held in ID.
module id_decode
   import lc3b_types::*;
(
   input  lc3b_word instruction,
   output lc3b_reg  src1,
   output lc3b_reg  src2,
   output lc3b_reg  dest,
   output logic     uses_sr1,
   output logic     uses_sr2
);

   lc3b_opcode opcode;
   logic [1:0] unused_bits;

   assign opcode      = lc3b_opcode'(instruction[15:12]);
   assign unused_bits = instruction[4:3];
   assign src1        = instruction[8:6];

   always_comb begin
      src2     = instruction[2:0];
      dest     = instruction[11:9];
      uses_sr1 = 1'b0;
      uses_sr2 = 1'b0;
      case (opcode)
         op_add, op_and: begin
            uses_sr1 = 1'b1;
            uses_sr2 = ~instruction[5];
         end
         op_str, op_stb, op_sti: begin
            // Store data sits in the dest field but is a read, not a write.
            src2     = instruction[11:9];
            uses_sr1 = 1'b1;
            uses_sr2 = 1'b1;
         end
         op_not, op_ldr, op_ldb, op_ldi, op_shf, op_jmp: begin
            uses_sr1 = 1'b1;
         end
         op_jsr: begin
            dest     = 3'd7;
            uses_sr1 = ~instruction[11];
         end
         op_trap: begin
            dest     = 3'd7;
         end
         default: begin
            uses_sr1 = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/id_stage.sv
// IF/ID pipeline register with load-use hazard detection and stall counter.
// state | meaning
// EMPTY | id_valid=0, nothing to issue
// HELD  | id_valid=1, instruction waits for or issues to EX
module id_stage
   import lc3b_types::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       if_valid,
   input  lc3b_word   if_pc,
   input  lc3b_word   if_instruction,
   input  logic       flush,
   input  logic       ex_stall,
   input  logic       ex_valid,
   input  logic       ex_load,
   input  lc3b_reg    ex_dest,
   output logic       id_valid,
   output lc3b_word   id_pc,
   output lc3b_word   id_instruction,
   output lc3b_opcode id_opcode,
   output lc3b_reg    id_src1,
   output lc3b_reg    id_src2,
   output lc3b_reg    id_dest,
   output logic       id_issue,
   output logic       stall_if,
   input  logic       id_stall_count_reset,
   output logic [15:0] id_stall_count
);

   logic uses_sr1;
   logic uses_sr2;
   logic hazard;

   id_decode u_decode (
      .instruction (id_instruction),
      .src1        (id_src1),
      .src2        (id_src2),
      .dest        (id_dest),
      .uses_sr1    (uses_sr1),
      .uses_sr2    (uses_sr2)
   );

   assign id_opcode = lc3b_opcode'(id_instruction[15:12]);

   assign hazard = id_valid & ex_valid & ex_load &
                   ((uses_sr1 & (id_src1 == ex_dest)) |
                    (uses_sr2 & (id_src2 == ex_dest)));

   assign id_issue = id_valid & ~hazard & ~ex_stall & ~flush;
   assign stall_if = id_valid & (hazard | ex_stall) & ~flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_valid       <= 1'b0;
         id_pc          <= '0;
         id_instruction <= nop_word;
      end else if (flush) begin
         id_valid       <= 1'b0;
      end else if (!stall_if) begin
         id_valid       <= if_valid;
         id_pc          <= if_pc;
         id_instruction <= if_instruction;
      end
   end

   // Only load-use bubbles are counted; back-pressure from EX is not.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_stall_count <= '0;
      end else if (id_stall_count_reset) begin
         id_stall_count <= '0;
      end else if (hazard & ~flush) begin
         id_stall_count <= id_stall_count + 16'd1;
      end
   end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the pipelined LC-3b core, directly downstream of the fetch stage. It holds the IF/ID pipeline register, decodes register usage of the held instruction, and detects load-use hazards against the instruction in EX. It drives the stall back to fetch, drops wrong-path instructions on a redirect, and counts hazard stall cycles for the performance counters.

## Interface
- No parameters; widths come from `lc3b_types`.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `if_valid` in 1: fetch presents a valid instruction this cycle.
- `if_pc` in 16 (`lc3b_word`): PC of the fetched instruction (already +2).
- `if_instruction` in 16 (`lc3b_word`): fetched instruction word.
- `flush` in 1: redirect taken this cycle (`br_en | trap_en | jmp_jsr_en`).
- `ex_stall` in 1: EX cannot accept an instruction this cycle.
- `ex_valid` in 1: EX holds a real instruction.
- `ex_load` in 1: EX instruction is LDR/LDB/LDI.
- `ex_dest` in 3 (`lc3b_reg`): destination register of the EX instruction.
- `id_valid` out 1: ID register holds a live instruction.
- `id_pc`, `id_instruction` out 16: registered copies.
- `id_opcode` out 4 (`lc3b_opcode`): `id_instruction[15:12]`.
- `id_src1`, `id_src2`, `id_dest` out 3: decoded register fields.
- `id_issue` out 1: instruction handed to EX this cycle.
- `stall_if` out 1: fetch must hold PC and IR.
- `id_stall_count_reset` in 1: synchronous counter clear.
- `id_stall_count` out 16: hazard stall cycles.

## Operation
- Field decode. `id_src1 = ir[8:6]`.
  - `id_src2 = ir[2:0]` for ADD/AND, `ir[11:9]` for STR/STB/STI.
  - `id_dest = 3'd7` for JSR/JSRR/TRAP, else `ir[11:9]`.
- Usage flags, from the registered instruction only:
  - `uses_sr1`: ADD, AND, NOT, LDR, LDB, LDI, STR, STB, STI, SHF, JMP, JSRR (JSR with `ir[11]=0`).
  - `uses_sr2`: ADD/AND with `ir[5]=0`, plus STR/STB/STI (store data).
- Hazard, combinational:
  - `hazard = id_valid & ex_valid & ex_load & ((uses_sr1 & id_src1==ex_dest) | (uses_sr2 & id_src2==ex_dest))`.
- `id_issue = id_valid & ~hazard & ~ex_stall & ~flush`.
- `stall_if = id_valid & (hazard | ex_stall) & ~flush`.
- Register update, in priority order:
  - `flush`: `id_valid<=0`, other fields hold.
  - `stall_if`: hold all state.
  - Otherwise load `if_valid`, `if_pc`, `if_instruction`.
- No internal FSM beyond `id_valid`. The two effective states are EMPTY (`id_valid=0`) and HELD (`id_valid=1`).
- Counter:
  - Clears when `id_stall_count_reset` is high.
  - Otherwise increments by 1 each cycle `hazard & ~flush` is high.
  - Wraps from 0xFFFF to 0.
  - `ex_stall`-only stalls are not counted.

## Timing
- Reset values: `id_valid=0`, `id_pc=0`, `id_instruction=0x0000` (BR never-taken, a NOP), `id_stall_count=0`.
  - Derived outputs at reset: `id_issue=0`, `stall_if=0`.
- Latency: an instruction accepted at edge N is visible on `id_*` after edge N and issues in cycle N+1 if there is no hazard.
- A load-use pair costs exactly 1 bubble. The hazard clears once EX advances, i.e. once the load leaves EX or `ex_valid` drops.
- `flush` together with a hazard or `ex_stall`: flush wins. ID empties, no issue, no count.
- `flush` together with `if_valid`: the fetched word is discarded.
- `if_valid=0` with no stall: ID goes EMPTY. This is a bubble, not a hold.
- R7 writers (JSR/TRAP) are never loads, so they cause no hazard here.
- `reset` asserted mid-stall: all state clears immediately and `stall_if` drops in the same cycle.

## Structure
- `lc3b_types` holds `lc3b_word`, `lc3b_reg`, and the `lc3b_opcode` enum (`op_add`, `op_and`, `op_br`, `op_jmp`, `op_jsr`, `op_ldb`, `op_ldi`, `op_ldr`, `op_lea`, `op_not`, `op_rti`, `op_shf`, `op_stb`, `op_sti`, `op_str`, `op_trap`).
- Sub-module `id_decode` is purely combinational: instruction in; src1, src2, dest, `uses_sr1`, `uses_sr2` out.
- `id_stage` holds the register, hazard logic and counter.

## Test plan
- Reset, then feed `ADD R1,R2,R3` (0x1283) at PC 0x3002 with `if_valid=1` -> next cycle `id_valid=1`, `id_src1=2`, `id_src2=3`, `id_dest=1`, `id_issue=1`.
- EX holds LDR to R2 (`ex_valid=1`, `ex_load=1`, `ex_dest=2`); ID holds `ADD R1,R2,#1` (0x12A1) -> `hazard=1`, `stall_if=1`, `id_issue=0` for one cycle, count 0->1. Drop `ex_valid` -> issues next cycle.
- ID holds `STR R4,R5,#0` (0x7940) with EX LDR to R4 -> stall, since store data counts as `uses_sr2`. The same instruction with `ex_dest=3` -> no stall.
- `flush=1` while ID is stalled on a hazard -> `id_valid=0` next cycle, `id_issue=0`, counter unchanged, `stall_if=0`.
- Preload the counter to 0xFFFF via hazard cycles, then one more hazard cycle -> 0x0000. Assert `id_stall_count_reset` during a hazard -> reads 0.
- Assert `reset` asynchronously while HELD with `ex_stall=1` -> `id_valid`, `stall_if` and counter all 0 before the next edge.
